// File: rtl/conv2_layer_ctrl_if.sv
// Bundle of the Conv2 sequencer's control, parameter-memory, engine and output-memory signals.
// master = the sequencer, slave = the surrounding memories, engine and register block.
interface conv2_layer_ctrl_if #(
   parameter int OUT_CH     = 16,
   parameter int DATA_WIDTH = 9,
   parameter int WADDR_W    = 11,
   parameter int OADDR_W    = 10
);
   logic                         start;
   logic                         reload_w;
   logic                         abort;
   logic                         busy;
   logic                         done;
   logic                         err;
   logic                         wmem_rd;
   logic [WADDR_W-1:0]           wmem_addr;
   logic signed [DATA_WIDTH-1:0] wmem_rdata;
   logic                         bmem_rd;
   logic [4:0]                   bmem_addr;
   logic [31:0]                  bmem_rdata;
   logic                         w_we;
   logic signed [DATA_WIDTH-1:0] w_data;
   logic [31:0]                  bias [0:OUT_CH-1];
   logic                         lb_start;
   logic                         eng_valid_out;
   logic [31:0]                  eng_data_out;
   logic [4:0]                   eng_out_ch;
   logic [2:0]                   eng_out_row;
   logic [2:0]                   eng_out_col;
   logic                         omem_we;
   logic [OADDR_W-1:0]           omem_addr;
   logic [31:0]                  omem_wdata;

   modport master (
      input  start, reload_w, abort, wmem_rdata, bmem_rdata,
             eng_valid_out, eng_data_out, eng_out_ch, eng_out_row, eng_out_col,
      output busy, done, err, wmem_rd, wmem_addr, bmem_rd, bmem_addr,
             w_we, w_data, bias, lb_start, omem_we, omem_addr, omem_wdata
   );

   modport slave (
      output start, reload_w, abort, wmem_rdata, bmem_rdata,
             eng_valid_out, eng_data_out, eng_out_ch, eng_out_row, eng_out_col,
      input  busy, done, err, wmem_rd, wmem_addr, bmem_rd, bmem_addr,
             w_we, w_data, bias, lb_start, omem_we, omem_addr, omem_wdata
   );
endinterface

// File: rtl/conv2_layer_ctrl.sv
// Conv2 stage sequencer: streams weights to the engine, loads the bias bank,
// kicks the line buffer and scatters pooled engine outputs into a CHW output memory.
module conv2_layer_ctrl #(
   parameter int IN_CH      = 8,
   parameter int OUT_CH     = 16,
   parameter int K_SIZE     = 3,
   parameter int POOL_H     = 7,
   parameter int POOL_W     = 7,
   parameter int DATA_WIDTH = 9,
   parameter int WADDR_W    = 11,
   parameter int OADDR_W    = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   conv2_layer_ctrl_if.master  bus
);
   localparam int N_W    = OUT_CH * K_SIZE * K_SIZE * IN_CH;
   localparam int N_O    = OUT_CH * POOL_H * POOL_W;
   localparam int CNT_W  = $clog2(N_O);
   localparam int BIDX_W = $clog2(OUT_CH);

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, RUN, DONE} state_t;

   state_t             state;
   logic               w_loaded;
   logic [CNT_W-1:0]   out_cnt;
   logic               w_vld_p1;
   logic               b_vld_p1;
   logic [4:0]         b_addr_p1;
   logic [31:0]        bias_q [0:OUT_CH-1];
   logic               coord_ok;
   logic               abort_act;

   function automatic logic [OADDR_W-1:0] chw_addr(input logic [4:0] ch,
                                                   input logic [2:0] row,
                                                   input logic [2:0] col);
      return OADDR_W'(ch) * OADDR_W'(POOL_H * POOL_W)
           + OADDR_W'(row) * OADDR_W'(POOL_W)
           + OADDR_W'(col);
   endfunction

   assign coord_ok  = ({1'b0, bus.eng_out_ch}  < 6'(OUT_CH))
                   && ({1'b0, bus.eng_out_row} < 4'(POOL_H))
                   && ({1'b0, bus.eng_out_col} < 4'(POOL_W));
   assign abort_act = bus.abort && (state != IDLE);

   assign bus.busy   = (state != IDLE);
   assign bus.w_we   = w_vld_p1;
   assign bus.w_data = w_vld_p1 ? bus.wmem_rdata : '0;
   assign bus.bias   = bias_q;

   // Read-return stage: memory data arrives one cycle after the read request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_vld_p1  <= 1'b0;
         b_vld_p1  <= 1'b0;
         b_addr_p1 <= '0;
         for (int i = 0; i < OUT_CH; i++) bias_q[i] <= '0;
      end else begin
         w_vld_p1  <= bus.wmem_rd && !abort_act;
         b_vld_p1  <= bus.bmem_rd && !abort_act;
         b_addr_p1 <= bus.bmem_addr;
         if (b_vld_p1) bias_q[b_addr_p1[BIDX_W-1:0]] <= bus.bmem_rdata;
      end
   end

   // Sequencer and output-write stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         w_loaded       <= 1'b0;
         out_cnt        <= '0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
         bus.wmem_rd    <= 1'b0;
         bus.wmem_addr  <= '0;
         bus.bmem_rd    <= 1'b0;
         bus.bmem_addr  <= '0;
         bus.lb_start   <= 1'b0;
         bus.omem_we    <= 1'b0;
         bus.omem_addr  <= '0;
         bus.omem_wdata <= '0;
      end else begin
         bus.done     <= 1'b0;
         bus.lb_start <= 1'b0;
         bus.omem_we  <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  bus.err <= 1'b0;
                  if (bus.reload_w || !w_loaded) begin
                     state         <= LOAD_W;
                     bus.wmem_rd   <= 1'b1;
                     bus.wmem_addr <= '0;
                  end else begin
                     state        <= RUN;
                     bus.lb_start <= 1'b1;
                  end
               end
            end
            LOAD_W: begin
               if (bus.wmem_addr == WADDR_W'(N_W - 1)) begin
                  state         <= LOAD_B;
                  bus.wmem_rd   <= 1'b0;
                  bus.bmem_rd   <= 1'b1;
                  bus.bmem_addr <= '0;
               end else begin
                  bus.wmem_addr <= bus.wmem_addr + 1'b1;
               end
            end
            LOAD_B: begin
               if (bus.bmem_addr == 5'(OUT_CH - 1)) begin
                  state        <= RUN;
                  bus.bmem_rd  <= 1'b0;
                  bus.lb_start <= 1'b1;
                  w_loaded     <= 1'b1;
               end else begin
                  bus.bmem_addr <= bus.bmem_addr + 1'b1;
               end
            end
            RUN: begin
               if (bus.eng_valid_out && coord_ok) begin
                  bus.omem_we    <= 1'b1;
                  bus.omem_addr  <= chw_addr(bus.eng_out_ch, bus.eng_out_row, bus.eng_out_col);
                  bus.omem_wdata <= bus.eng_data_out;
                  if (out_cnt == CNT_W'(N_O - 1)) begin
                     out_cnt  <= '0;
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end else begin
                     out_cnt <= out_cnt + 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         // A stray or malformed engine output is flagged and dropped
         if (bus.eng_valid_out && ((state != RUN) || !coord_ok)) bus.err <= 1'b1;

         if (abort_act) begin
            state        <= IDLE;
            out_cnt      <= '0;
            bus.wmem_rd  <= 1'b0;
            bus.bmem_rd  <= 1'b0;
            bus.lb_start <= 1'b0;
            bus.done     <= 1'b0;
            bus.omem_we  <= 1'b0;
            if (state == LOAD_W || state == LOAD_B) w_loaded <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_conv2_layer_ctrl.sv
// Directed bench for conv2_layer_ctrl: weight/bias load, CHW scatter, error flag and abort.
module tb_conv2_layer_ctrl;
   localparam int DW = 9;

   typedef struct {
      logic [4:0]  ch;
      logic [2:0]  row;
      logic [2:0]  col;
      logic [31:0] data;
      logic        exp_we;
      logic [9:0]  exp_addr;
      logic        exp_err;
   } vec_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp, n_fail;
   int   t0ref;
   int   w_cnt, w_err, rd_cnt, first_w_cyc, last_w_cyc;
   int   lb_cnt, lb_cyc, done_cnt, we_cnt;
   logic done_we;
   logic [31:0] omem_img [0:1023];

   conv2_layer_ctrl_if #(.OUT_CH(16), .DATA_WIDTH(DW), .WADDR_W(11), .OADDR_W(10)) bus ();

   conv2_layer_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory models: synchronous read, one cycle latency
   always @(posedge clk) begin
      if (bus.wmem_rd) bus.wmem_rdata <= DW'(bus.wmem_addr);
      if (bus.bmem_rd) bus.bmem_rdata <= 32'hB1A5_0000 + 32'(bus.bmem_addr) * 32'h0101;
      if (bus.omem_we) omem_img[bus.omem_addr] <= bus.omem_wdata;
   end

   always @(negedge clk) begin
      logic [DW-1:0] exp_w;
      if (bus.wmem_rd) rd_cnt++;
      if (bus.w_we) begin
         exp_w = w_cnt[DW-1:0];
         if (w_cnt == 0) first_w_cyc = cyc;
         last_w_cyc = cyc;
         if (bus.w_data !== exp_w) w_err++;
         w_cnt++;
      end
      if (bus.lb_start) begin lb_cnt++; lb_cyc = cyc; end
      if (bus.omem_we) we_cnt++;
      if (bus.done) begin done_cnt++; done_we = bus.omem_we; end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_counts();
      w_cnt = 0; w_err = 0; rd_cnt = 0; first_w_cyc = 0; last_w_cyc = 0;
      lb_cyc = 0; we_cnt = 0;
   endtask

   task automatic do_start(input logic rl);
      @(negedge clk);
      bus.start = 1'b1; bus.reload_w = rl;
      @(negedge clk);
      bus.start = 1'b0; bus.reload_w = 1'b0;
      t0ref = cyc;
      #1;
   endtask

   task automatic wait_lb(input int lb_before, input int max);
      int n = 0;
      while (lb_cnt == lb_before && n < max) begin
         @(negedge clk); #1; n++;
      end
      chk("lb_start_seen", 32'(lb_cnt != lb_before), 32'd1);
   endtask

   task automatic drive_eng(input logic v, input logic [4:0] ch, input logic [2:0] row,
                            input logic [2:0] col, input logic [31:0] d);
      bus.eng_valid_out = v; bus.eng_out_ch = ch; bus.eng_out_row = row;
      bus.eng_out_col = col; bus.eng_data_out = d;
   endtask

   function automatic logic [31:0] dat(input int j);
      return 32'h5A00_0000 + 32'(j) * 32'h0001_0003;
   endfunction

   initial begin
      vec_t tbl [11];
      int   lb0, we0, done0, errs, j, w_at_abort;

      tbl[0]  = '{5'd0,  3'd0, 3'd0, 32'h1111_0000, 1'b1, 10'd0,   1'b0};
      tbl[1]  = '{5'd3,  3'd6, 3'd2, 32'h2222_0191, 1'b1, 10'd191, 1'b0};
      tbl[2]  = '{5'd15, 3'd6, 3'd6, 32'hFFFF_0783, 1'b1, 10'd783, 1'b0};
      tbl[3]  = '{5'd1,  3'd0, 3'd0, 32'h0000_0049, 1'b1, 10'd49,  1'b0};
      tbl[4]  = '{5'd0,  3'd1, 3'd0, 32'h8000_0007, 1'b1, 10'd7,   1'b0};
      tbl[5]  = '{5'd7,  3'd3, 3'd5, 32'h1234_5678, 1'b1, 10'd369, 1'b0};
      tbl[6]  = '{5'd10, 3'd2, 3'd4, 32'hDEAD_BEEF, 1'b1, 10'd508, 1'b0};
      tbl[7]  = '{5'd0,  3'd0, 3'd7, 32'hBAD0_0001, 1'b0, 10'd0,   1'b1};
      tbl[8]  = '{5'd16, 3'd0, 3'd0, 32'hBAD0_0002, 1'b0, 10'd0,   1'b1};
      tbl[9]  = '{5'd2,  3'd7, 3'd1, 32'hBAD0_0003, 1'b0, 10'd0,   1'b1};
      tbl[10] = '{5'd9,  3'd5, 3'd3, 32'h0C0F_FEE0, 1'b1, 10'd479, 1'b1};

      n_cmp = 0; n_fail = 0; lb_cnt = 0; done_cnt = 0; done_we = 1'b0;
      clr_counts();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.reload_w = 1'b0; bus.abort = 1'b0;
      drive_eng(1'b0, 5'd0, 3'd0, 3'd0, 32'd0);

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_err",      32'(bus.err),      32'd0);
      chk("rst_wmem_rd",  32'(bus.wmem_rd),  32'd0);
      chk("rst_w_we",     32'(bus.w_we),     32'd0);
      chk("rst_omem_we",  32'(bus.omem_we),  32'd0);
      chk("rst_lb_start", 32'(bus.lb_start), 32'd0);
      chk("rst_bias3",    bus.bias[3],       32'd0);
      @(negedge clk); rst_n = 1'b1;

      // First start without reload_w: weights not yet loaded, so a load is forced
      clr_counts(); lb0 = lb_cnt;
      do_start(1'b0);
      chk("load_busy", 32'(bus.busy), 32'd1);
      wait_lb(lb0, 2000);
      chk("w_we_count",   32'(w_cnt), 32'd1152);
      chk("w_data_order", 32'(w_err), 32'd0);
      chk("wmem_rd_count", 32'(rd_cnt), 32'd1152);
      chk("first_w_we_cyc", 32'(first_w_cyc - t0ref + 1), 32'd2);
      chk("last_w_we_cyc",  32'(last_w_cyc - t0ref + 1), 32'd1153);
      chk("lb_start_cyc",   32'(lb_cyc - t0ref + 1), 32'd1169);
      @(negedge clk); #1;
      chk("lb_start_one_cycle", 32'(lb_cnt - lb0), 32'd1);
      for (int i = 0; i < 16; i++)
         chk("bias_bank", bus.bias[i], 32'hB1A5_0000 + 32'(i) * 32'h0101);

      // Table of single engine outputs during RUN
      for (int i = 0; i < 11; i++) begin
         drive_eng(1'b1, tbl[i].ch, tbl[i].row, tbl[i].col, tbl[i].data);
         @(negedge clk); #1;
         chk("tbl_we", 32'(bus.omem_we), 32'(tbl[i].exp_we));
         if (tbl[i].exp_we) begin
            chk("tbl_addr",  32'(bus.omem_addr), 32'(tbl[i].exp_addr));
            chk("tbl_wdata", bus.omem_wdata, tbl[i].data);
         end
         chk("tbl_err", 32'(bus.err), 32'(tbl[i].exp_err));
      end
      drive_eng(1'b0, 5'd0, 3'd0, 3'd0, 32'd0);

      // Abort in RUN keeps the loaded weights
      bus.abort = 1'b1;
      @(negedge clk); bus.abort = 1'b0; #1;
      chk("abort_run_busy", 32'(bus.busy), 32'd0);
      chk("abort_run_done", 32'(done_cnt), 32'd0);

      // Second start, no reload: straight to RUN, full scrambled stream
      for (int k = 0; k < 1024; k++) omem_img[k] = 32'd0;
      clr_counts(); lb0 = lb_cnt;
      do_start(1'b0);
      chk("err_cleared", 32'(bus.err), 32'd0);
      wait_lb(lb0, 10);
      chk("noreload_lb_cyc", 32'(lb_cyc - t0ref + 1), 32'd1);
      for (int i = 0; i < 784; i++) begin
         if (i == 400) begin
            we0 = we_cnt;
            drive_eng(1'b1, 5'd2, 3'd3, 3'd7, 32'hBAD0_BAD0);
            @(negedge clk); #1;
            chk("bad_col_err", 32'(bus.err), 32'd1);
            chk("bad_col_nowrite", 32'(we_cnt), 32'(we0));
         end
         j = (i * 397) % 784;
         if (i == 783) chk("done_not_early", 32'(done_cnt), 32'd0);
         drive_eng(1'b1, 5'(j / 49), 3'((j % 49) / 7), 3'(j % 7), dat(j));
         @(negedge clk); #1;
      end
      drive_eng(1'b0, 5'd0, 3'd0, 3'd0, 32'd0);
      chk("noreload_w_we",   32'(w_cnt), 32'd0);
      chk("noreload_wmem_rd", 32'(rd_cnt), 32'd0);
      chk("done_count",      32'(done_cnt), 32'd1);
      chk("done_with_we",    32'(done_we), 32'd1);
      chk("omem_we_count",   32'(we_cnt), 32'd784);
      @(negedge clk); #1;
      chk("idle_after_done", 32'(bus.busy), 32'd0);
      errs = 0;
      for (int k = 0; k < 784; k++) if (omem_img[k] !== dat(k)) errs++;
      chk("omem_image_errs", 32'(errs), 32'd0);

      // Engine output while IDLE
      we0 = we_cnt;
      drive_eng(1'b1, 5'd1, 3'd1, 3'd1, 32'h0000_0001);
      @(negedge clk);
      drive_eng(1'b0, 5'd0, 3'd0, 3'd0, 32'd0);
      #1;
      chk("idle_valid_err", 32'(bus.err), 32'd1);
      chk("idle_valid_nowrite", 32'(we_cnt), 32'(we0));

      // Reload, abort at LOAD_W cycle 500
      clr_counts(); done0 = done_cnt;
      do_start(1'b1);
      chk("reload_err_cleared", 32'(bus.err), 32'd0);
      repeat (499) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk); bus.abort = 1'b0; #1;
      w_at_abort = w_cnt;
      chk("abort_lw_busy", 32'(bus.busy), 32'd0);
      chk("abort_lw_w_we", 32'(bus.w_we), 32'd0);
      chk("abort_lw_wcount", 32'(w_at_abort), 32'd499);
      repeat (20) @(negedge clk);
      #1;
      chk("abort_no_more_w_we", 32'(w_cnt), 32'(w_at_abort));
      chk("abort_no_done", 32'(done_cnt), 32'(done0));

      // Start without reload after the aborted load: full reload again
      clr_counts(); lb0 = lb_cnt;
      do_start(1'b0);
      wait_lb(lb0, 2000);
      chk("reload2_w_we", 32'(w_cnt), 32'd1152);
      chk("reload2_order", 32'(w_err), 32'd0);
      chk("reload2_lb_cyc", 32'(lb_cyc - t0ref + 1), 32'd1169);
      bus.abort = 1'b1;
      @(negedge clk); bus.abort = 1'b0; #1;
      chk("abort2_busy", 32'(bus.busy), 32'd0);

      // Start and abort together in IDLE: start dropped
      @(negedge clk);
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      #1;
      chk("start_abort_busy", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
